wall_mask_store: RTL and testbench

- Parametrised multi-mask wall store; successor to the single-port whole-mask ROM.
- Stores NUM_MASKS down-sampled wall masks, one BRAM word per mask row.
- Answers per-pixel queries from the video pipeline at a fixed latency.
- Mask select uses a valid/ready handshake and takes effect only at frame start, so there is no tearing. A write port lets game logic rewrite rows at runtime.

---
 rtl/wall_mask_pkg.sv | 16 +
 rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv | 37 +++
 rtl/wall_mask_store.sv | 145 ++++++++++++++
 tb/tb_wall_mask_store.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/wall_mask_pkg.sv
// Shared constants and the select-FSM state type for the wall mask store
// (defaults describe the 1280x720, 16-pixel-cell, 16-mask configuration).
package wall_mask_pkg;
    localparam int NUM_MASKS_DEF = 16;
    localparam int MW            = 1280 / 16;
    localparam int MH            = 720 / 16;
    localparam int DEPTH         = NUM_MASKS_DEF * MH;
    localparam int IDXW          = $clog2(NUM_MASKS_DEF);
    localparam int ROWW          = $clog2(MH);
    localparam int LATENCY       = 4;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } sel_state_t;
endpackage

// File: rtl/xilinx_true_dual_port_read_first_1_clock_ram.sv
// Single-clock dual-port block RAM: port A read-only, port B write-only, read-first.
// HIGH_PERFORMANCE adds an output register, giving a 2-cycle read.
module xilinx_true_dual_port_read_first_1_clock_ram #(
    parameter int RAM_WIDTH       = 80,
    parameter int RAM_DEPTH       = 720,
    parameter     RAM_PERFORMANCE = "HIGH_PERFORMANCE",
    parameter     INIT_FILE       = "",
    localparam int AW             = $clog2(RAM_DEPTH)
) (
    input  logic                 clka,
    input  logic [AW-1:0]        addra,
    output logic [RAM_WIDTH-1:0] douta,
    input  logic [AW-1:0]        addrb,
    input  logic [RAM_WIDTH-1:0] dinb,
    input  logic                 web
);
    logic [RAM_WIDTH-1:0] mem [RAM_DEPTH];
    logic [RAM_WIDTH-1:0] ram_q;

    initial begin
        for (int i = 0; i < RAM_DEPTH; i++) mem[i] = '0;
    end

    // Non-blocking write and read in the same block: a colliding read sees old data.
    always_ff @(posedge clka) begin
        if (web) mem[addrb] <= dinb;
        ram_q <= mem[addra];
    end

    if (RAM_PERFORMANCE == "HIGH_PERFORMANCE") begin : g_outreg
        logic [RAM_WIDTH-1:0] reg_q;
        always_ff @(posedge clka) reg_q <= ram_q;
        assign douta = reg_q;
    end else begin : g_noreg
        assign douta = ram_q;
    end
endmodule

// File: rtl/wall_mask_store.sv
// Multi-mask wall store: fixed 4-cycle per-pixel lookups, frame-synchronous
// mask switching via a valid/ready select, and a runtime row-write port.
module wall_mask_store
    import wall_mask_pkg::*;
#(
    parameter int SCREEN_WIDTH       = 1280,
    parameter int SCREEN_HEIGHT      = 720,
    parameter int DOWN_SAMPLE_FACTOR = 16,
    parameter int NUM_MASKS          = 16,
    parameter     INIT_FILE          = "walls.mem",
    localparam int MASK_W            = SCREEN_WIDTH / DOWN_SAMPLE_FACTOR,
    localparam int MASK_H            = SCREEN_HEIGHT / DOWN_SAMPLE_FACTOR,
    localparam int IW                = $clog2(NUM_MASKS),
    localparam int RW                = $clog2(MASK_H)
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic [10:0]       hcount_in,
    input  logic [9:0]        vcount_in,
    input  logic              pix_valid_in,
    output logic              mask_bit_out,
    output logic              mask_valid_out,
    input  logic              sel_valid_in,
    input  logic [IW-1:0]     sel_idx_in,
    output logic              sel_ready_out,
    output logic [IW-1:0]     active_idx_out,
    input  logic              wr_valid_in,
    input  logic [IW-1:0]     wr_idx_in,
    input  logic [RW-1:0]     wr_row_in,
    input  logic [MASK_W-1:0] wr_data_in,
    output logic              err_out
);
    localparam int DEP = NUM_MASKS * MASK_H;
    localparam int AW  = $clog2(DEP);
    localparam int CW  = $clog2(MASK_W);
    localparam int DSL = $clog2(DOWN_SAMPLE_FACTOR);

    // Reset asserts immediately, releases two clocks later on a clean edge.
    logic [1:0] rst_sync_q;
    logic       rst;
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) rst_sync_q <= 2'b11;
        else        rst_sync_q <= {rst_sync_q[0], 1'b0};
    end
    assign rst = rst_sync_q[1];

    sel_state_t    state_q, state_d;
    logic [IW-1:0] pend_q, pend_d, active_q, active_d, idx_sel;
    logic          fs, sel_ok, sel_bad, wr_ok, err_q;

    assign fs     = (hcount_in == '0) && (vcount_in == '0);
    assign sel_ok = 32'(sel_idx_in) < NUM_MASKS;
    assign wr_ok  = (32'(wr_idx_in) < NUM_MASKS) && (32'(wr_row_in) < MASK_H);

    always_comb begin
        state_d  = state_q;
        pend_d   = pend_q;
        active_d = active_q;
        sel_bad  = 1'b0;
        case (state_q)
            IDLE: if (sel_valid_in) begin
                if (sel_ok) begin
                    pend_d  = sel_idx_in;
                    state_d = PENDING;
                end else begin
                    sel_bad = 1'b1;
                end
            end
            PENDING: if (fs) begin
                active_d = pend_q;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pend_q   <= '0;
            active_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            pend_q   <= pend_d;
            active_q <= active_d;
            err_q    <= sel_bad | (wr_valid_in & ~wr_ok);
        end
    end

    // The frame-start pixel already looks up the mask being switched in.
    assign idx_sel = (state_q == PENDING && fs) ? pend_q : active_q;

    logic                       pix_ok;
    logic [RW-1:0]              row_d;
    logic [CW-1:0]              col_d;
    logic [AW-1:0]              addr_d, addr_q, wr_addr;
    logic [LATENCY-1:1]         vld_pipe_q;
    logic [LATENCY-1:1][CW-1:0] col_pipe_q;
    logic [MASK_W-1:0]          ram_dout;
    logic                       mask_valid_q, mask_bit_q;

    assign pix_ok  = pix_valid_in && (32'(hcount_in) < SCREEN_WIDTH)
                                  && (32'(vcount_in) < SCREEN_HEIGHT);
    assign row_d   = RW'(vcount_in >> DSL);
    assign col_d   = CW'(hcount_in >> DSL);
    assign addr_d  = AW'(32'(idx_sel) * MASK_H + 32'(row_d));
    assign wr_addr = AW'(32'(wr_idx_in) * MASK_H + 32'(wr_row_in));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            vld_pipe_q   <= '0;
            col_pipe_q   <= '0;
            addr_q       <= '0;
            mask_valid_q <= 1'b0;
            mask_bit_q   <= 1'b0;
        end else begin
            vld_pipe_q   <= {vld_pipe_q[LATENCY-2:1], pix_ok};
            col_pipe_q   <= {col_pipe_q[LATENCY-2:1], col_d};
            addr_q       <= addr_d;
            mask_valid_q <= vld_pipe_q[LATENCY-1];
            mask_bit_q   <= vld_pipe_q[LATENCY-1] & ram_dout[col_pipe_q[LATENCY-1]];
        end
    end

    xilinx_true_dual_port_read_first_1_clock_ram #(
        .RAM_WIDTH       (MASK_W),
        .RAM_DEPTH       (DEP),
        .RAM_PERFORMANCE ("HIGH_PERFORMANCE"),
        .INIT_FILE       (INIT_FILE)
    ) u_ram (
        .clka  (clk_in),
        .addra (addr_q),
        .douta (ram_dout),
        .addrb (wr_addr),
        .dinb  (wr_data_in),
        .web   (wr_valid_in & wr_ok)
    );

    assign mask_bit_out   = mask_bit_q;
    assign mask_valid_out = mask_valid_q;
    assign sel_ready_out  = (state_q == IDLE);
    assign active_idx_out = active_q;
    assign err_out        = err_q;
endmodule

// File: tb/tb_wall_mask_store.sv
// Directed bench for wall_mask_store: lookups, frame-synchronous select,
// write port and error pulses, a streaming segment and mid-line reset.
module tb_wall_mask_store;
    import wall_mask_pkg::*;

    localparam int NM = 12;

    logic          clk = 1'b0;
    logic          rst_in;
    logic [10:0]   hc;
    logic [9:0]    vc;
    logic          pv, selv, wrv;
    logic [3:0]    seli, wri;
    logic [5:0]    wrr;
    logic [MW-1:0] wrd;
    logic          mask_bit_out, mask_valid_out, sel_ready_out, err_out;
    logic [3:0]    active_idx_out;

    logic [MW-1:0] ref_mem [NM*MH];
    int            n_chk = 0;
    int            n_pass = 0;
    logic [1:0]    exp_q [$];

    always #5 clk = ~clk;

    wall_mask_store #(
        .SCREEN_WIDTH(1280), .SCREEN_HEIGHT(720), .DOWN_SAMPLE_FACTOR(16),
        .NUM_MASKS(NM), .INIT_FILE("")
    ) dut (
        .clk_in(clk), .rst_in(rst_in), .hcount_in(hc), .vcount_in(vc),
        .pix_valid_in(pv), .mask_bit_out(mask_bit_out), .mask_valid_out(mask_valid_out),
        .sel_valid_in(selv), .sel_idx_in(seli), .sel_ready_out(sel_ready_out),
        .active_idx_out(active_idx_out), .wr_valid_in(wrv), .wr_idx_in(wri),
        .wr_row_in(wrr), .wr_data_in(wrd), .err_out(err_out)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle();
        pv = 1'b0; hc = 11'd100; vc = 10'd100;
    endtask

    task automatic wr(input int m, input int r, input logic [MW-1:0] d);
        wrv = 1'b1; wri = 4'(m); wrr = 6'(r); wrd = d;
        step();
        wrv = 1'b0;
        if (m < NM && r < MH) ref_mem[m*MH + r] = d;
    endtask

    function automatic logic model_bit(input int m, input int h, input int v);
        logic [MW-1:0] w;
        if (h >= 1280 || v >= 720) return 1'b0;
        w = ref_mem[m*MH + v/16];
        return w[h/16];
    endfunction

    task automatic query(input string tag, input int h, input int v, input logic eb);
        pv = 1'b1; hc = 11'(h); vc = 10'(v);
        step();
        idle();
        repeat (3) step();
        chk({tag, "_vld"}, 32'(mask_valid_out), 32'd1);
        chk({tag, "_bit"}, 32'(mask_bit_out), 32'(eb));
    endtask

    // One streamed pixel per cycle; result of the pixel 3 pushes earlier is checked.
    task automatic stream_px(input int m, input int h, input int v);
        logic [1:0] e;
        pv = 1'b1; hc = 11'(h); vc = 10'(v);
        exp_q.push_back({(h < 1280 && v < 720) ? 1'b1 : 1'b0, model_bit(m, h, v)});
        step();
        if (exp_q.size() == 4) begin
            e = exp_q.pop_front();
            chk("stream_vld", 32'(mask_valid_out), 32'(e[1]));
            chk("stream_bit", 32'(mask_bit_out), 32'(e[0]));
        end
    endtask

    initial begin
        logic [95:0] rnd;
        logic [1:0]  e;
        for (int i = 0; i < NM*MH; i++) ref_mem[i] = '0;
        rst_in = 1'b1; selv = 1'b0; seli = '0; wrv = 1'b0; wri = '0; wrr = '0; wrd = '0;
        idle();
        repeat (3) step();
        chk("rst_ready", 32'(sel_ready_out), 32'd1);
        chk("rst_vld", 32'(mask_valid_out), 32'd0);
        chk("rst_bit", 32'(mask_bit_out), 32'd0);
        chk("rst_err", 32'(err_out), 32'd0);
        chk("rst_active", 32'(active_idx_out), 32'd0);
        rst_in = 1'b0;
        repeat (3) step();

        wr(0, 3, MW'(4));
        wr(0, 0, '0);
        wr(5, 0, '1);
        wr(5, 3, '0);
        step();
        query("q37_50", 37, 50, 1'b1);
        query("q48_50", 48, 50, 1'b0);

        // Mid-frame select: held pending, mask 0 still displayed
        selv = 1'b1; seli = 4'd5;
        step();
        selv = 1'b0;
        chk("pend_ready", 32'(sel_ready_out), 32'd0);
        chk("pend_active", 32'(active_idx_out), 32'd0);
        chk("pend_err", 32'(err_out), 32'd0);
        query("pend_q", 37, 50, 1'b1);

        // Frame-start pixel already reads mask 5 (row 0 all ones)
        pv = 1'b1; hc = '0; vc = '0;
        step();
        idle();
        chk("fs_active", 32'(active_idx_out), 32'd5);
        chk("fs_ready", 32'(sel_ready_out), 32'd1);
        repeat (3) step();
        chk("fs_pix_vld", 32'(mask_valid_out), 32'd1);
        chk("fs_pix_bit", 32'(mask_bit_out), 32'd1);
        query("m5_q37_50", 37, 50, 1'b0);

        // Row 45 of mask 4 would alias mask 5 row 0 if not suppressed
        wr(4, 45, '0);
        chk("badrow_err", 32'(err_out), 32'd1);
        step();
        chk("badrow_err_end", 32'(err_out), 32'd0);
        query("badrow_intact", 20, 5, 1'b1);

        selv = 1'b1; seli = 4'd13; wrv = 1'b1; wri = 4'd12; wrr = '0; wrd = '1;
        step();
        selv = 1'b0; wrv = 1'b0;
        chk("dual_err", 32'(err_out), 32'd1);
        chk("badsel_active", 32'(active_idx_out), 32'd5);
        chk("badsel_ready", 32'(sel_ready_out), 32'd1);
        step();
        chk("dual_err_end", 32'(err_out), 32'd0);

        // Select accepted on a frame-start cycle waits for the next one
        selv = 1'b1; seli = 4'd0; hc = '0; vc = '0;
        step();
        selv = 1'b0;
        idle();
        chk("fssel_ready", 32'(sel_ready_out), 32'd0);
        chk("fssel_active", 32'(active_idx_out), 32'd5);
        query("fssel_q", 20, 5, 1'b1);
        hc = '0; vc = '0;
        step();
        idle();
        chk("fs2_active", 32'(active_idx_out), 32'd0);
        chk("fs2_ready", 32'(sel_ready_out), 32'd1);

        wr(0, 3, '1);
        step();
        query("wr_vis", 700, 55, 1'b1);

        for (int r = 0; r < MH; r++) begin
            rnd = {$urandom(), $urandom(), $urandom()};
            wr(0, r, rnd[MW-1:0]);
        end
        step();
        for (int h = 0; h < 1300; h++) stream_px(0, h, 300);
        for (int h = 1260; h < 1300; h++) stream_px(0, h, 719);
        for (int h = 0; h < 10; h++) stream_px(0, h, 720);
        for (int i = 0; i < 200; i++)
            stream_px(0, int'($urandom_range(1400, 0)), int'($urandom_range(760, 1)));
        idle();
        while (exp_q.size() > 0) begin
            step();
            e = exp_q.pop_front();
            chk("drain_vld", 32'(mask_valid_out), 32'(e[1]));
            chk("drain_bit", 32'(mask_bit_out), 32'(e[0]));
        end

        // Mid-line async reset with queries in flight and a select pending
        selv = 1'b1; seli = 4'd7;
        step();
        selv = 1'b0; hc = '0; vc = '0;
        step();
        idle();
        chk("pre_rst_active", 32'(active_idx_out), 32'd7);
        selv = 1'b1; seli = 4'd3;
        step();
        selv = 1'b0;
        for (int i = 0; i < 3; i++) begin
            pv = 1'b1; hc = 11'(37 + i*16); vc = 10'd50;
            step();
        end
        idle();
        #2 rst_in = 1'b1;
        #1;
        chk("arst_vld", 32'(mask_valid_out), 32'd0);
        chk("arst_bit", 32'(mask_bit_out), 32'd0);
        chk("arst_active", 32'(active_idx_out), 32'd0);
        chk("arst_ready", 32'(sel_ready_out), 32'd1);
        step();
        rst_in = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("post_rst_vld", 32'(mask_valid_out), 32'd0);
        end
        query("rst_requery", 37, 50, model_bit(0, 37, 50));
        query("rst_requery2", 1279, 719, model_bit(0, 1279, 719));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
